// File: rtl/rv32_barrel_irq_dispatch.sv
// rv32_barrel_irq_dispatch
//   Interrupt front end for the barrel core. Runs the hart slot counter,
//   captures edge-triggered interrupt events per hart (external, IPI, timer,
//   MVU) and, in each hart's slot, presents that hart's highest-priority
//   pending interrupt with its mcause code. A pending bit is held until the
//   core acknowledges the presented trap in that hart's slot.
//
//   Build option: define PITO_IRQ_SYNC_EN to put a 2-flop synchronizer in
//   front of every interrupt input (capture latency 2 edges). Without it the
//   inputs are taken as synchronous to clk (capture on the sampling edge).
//
// Ports
//   clk, rst_n         core clock, asynchronous active-low reset
//   enable_i           advance the slot counter (holds when low)
//   irq_i, ipi_i,
//   time_irq_i,
//   mvu_irq_i          per-hart interrupt sources, one bit per hart
//   irq_ack_i          core took the presented trap in the current slot
//   hart_id_o          current slot hart (registered)
//   irq_valid_o        current hart has a pending interrupt
//   irq_o, ipi_o,
//   time_irq_o,
//   mvu_irq_o          one-hot presented source
//   cause_o            mcause of the presented source, 0 when none
module rv32_barrel_irq_dispatch #(
    parameter int NUM_HARTS      = 8,
    parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic [NUM_HARTS-1:0]      irq_i,
    input  logic [NUM_HARTS-1:0]      ipi_i,
    input  logic [NUM_HARTS-1:0]      time_irq_i,
    input  logic [NUM_HARTS-1:0]      mvu_irq_i,
    input  logic                      irq_ack_i,
    output logic [HART_CNT_WIDTH-1:0] hart_id_o,
    output logic                      irq_valid_o,
    output logic                      irq_o,
    output logic                      ipi_o,
    output logic                      time_irq_o,
    output logic                      mvu_irq_o,
    output logic [31:0]               cause_o
);

    localparam int unsigned NH    = NUM_HARTS;
    localparam int unsigned NSRC  = 4;
    localparam int unsigned NBITS = NSRC * NH;

    localparam logic [HART_CNT_WIDTH-1:0] LAST_HART = HART_CNT_WIDTH'(NUM_HARTS - 1);
    localparam logic [HART_CNT_WIDTH-1:0] ONE       = HART_CNT_WIDTH'(1);

    localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
    localparam logic [31:0] CAUSE_IPI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MVU = 32'h8000_0010;

    logic [HART_CNT_WIDTH-1:0] hart_id_q, hart_id_d;

    // Flat event vector: source s of hart h lives at bit s*NH + h,
    // with s = 0 external, 1 ipi, 2 timer, 3 mvu.
    logic [NBITS-1:0] raw;
    logic [NBITS-1:0] in_s;
    logic [NBITS-1:0] prev_q;
    logic [NBITS-1:0] pend_q, pend_d;
    logic [NBITS-1:0] rise;
    logic [NBITS-1:0] clr;

    logic [NSRC-1:0] cur;   // pending bits of the current slot's hart
    logic [NSRC-1:0] pick;  // one-hot presented source

    assign raw = {mvu_irq_i, time_irq_i, ipi_i, irq_i};

`ifdef PITO_IRQ_SYNC_EN
    logic [NBITS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    assign in_s = sync2_q;
`else
    assign in_s = raw;
`endif

    assign rise = in_s & ~prev_q;

    // Slot counter with explicit wrap so non-power-of-two hart counts work.
    always_comb begin
        hart_id_d = hart_id_q;
        if (enable_i) begin
            if (hart_id_q == LAST_HART) hart_id_d = '0;
            else                        hart_id_d = hart_id_q + ONE;
        end
    end

    always_comb begin
        cur = '0;
        for (int unsigned s = 0; s < NSRC; s++) begin
            cur[s] = pend_q[s * NH + 32'(hart_id_q)];
        end
    end

    // Fixed priority: external > ipi > timer > mvu.
    always_comb begin
        pick        = '0;
        irq_o       = 1'b0;
        ipi_o       = 1'b0;
        time_irq_o  = 1'b0;
        mvu_irq_o   = 1'b0;
        cause_o     = '0;
        irq_valid_o = |cur;
        if (cur[0]) begin
            pick[0] = 1'b1;
            irq_o   = 1'b1;
            cause_o = CAUSE_EXT;
        end else if (cur[1]) begin
            pick[1] = 1'b1;
            ipi_o   = 1'b1;
            cause_o = CAUSE_IPI;
        end else if (cur[2]) begin
            pick[2]    = 1'b1;
            time_irq_o = 1'b1;
            cause_o    = CAUSE_TMR;
        end else if (cur[3]) begin
            pick[3]   = 1'b1;
            mvu_irq_o = 1'b1;
            cause_o   = CAUSE_MVU;
        end
    end

    // pick is all-zero when nothing is pending, so an idle ack clears nothing.
    always_comb begin
        clr = '0;
        for (int unsigned s = 0; s < NSRC; s++) begin
            clr[s * NH + 32'(hart_id_q)] = irq_ack_i & pick[s];
        end
    end

    // Set after clear: an event arriving on the ack edge is retained.
    assign pend_d = (pend_q & ~clr) | rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hart_id_q <= '0;
            prev_q    <= '0;
            pend_q    <= '0;
        end else begin
            hart_id_q <= hart_id_d;
            prev_q    <= in_s;
            pend_q    <= pend_d;
        end
    end

    assign hart_id_o = hart_id_q;

endmodule

// File: tb/tb_rv32_barrel_irq_dispatch.sv
// Directed bench for rv32_barrel_irq_dispatch (NUM_HARTS=8, plus a
// NUM_HARTS=6 instance for the counter wrap). Expected values are
// hand-derived; the slot counter is tracked by a small model in tick().
module tb_rv32_barrel_irq_dispatch;

`ifdef PITO_IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    localparam logic [31:0] C_EXT = 32'h8000_000B;
    localparam logic [31:0] C_IPI = 32'h8000_0003;
    localparam logic [31:0] C_TMR = 32'h8000_0007;
    localparam logic [31:0] C_MVU = 32'h8000_0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_i;
    logic [7:0]  irq_i, ipi_i, time_irq_i, mvu_irq_i;
    logic        irq_ack_i;
    logic [2:0]  hart_id_o;
    logic        irq_valid_o, irq_o, ipi_o, time_irq_o, mvu_irq_o;
    logic [31:0] cause_o;

    logic [5:0]  zero6 = '0;
    logic [2:0]  hart6;
    logic        v6, i6, p6, t6, m6;
    logic [31:0] c6;

    int total = 0;
    int bad   = 0;
    int exp_hart = 0;
    int exp6     = 0;

    always #5 clk = ~clk;

    rv32_barrel_irq_dispatch #(.NUM_HARTS(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
        .irq_i(irq_i), .ipi_i(ipi_i), .time_irq_i(time_irq_i), .mvu_irq_i(mvu_irq_i),
        .irq_ack_i(irq_ack_i), .hart_id_o(hart_id_o), .irq_valid_o(irq_valid_o),
        .irq_o(irq_o), .ipi_o(ipi_o), .time_irq_o(time_irq_o), .mvu_irq_o(mvu_irq_o),
        .cause_o(cause_o)
    );

    rv32_barrel_irq_dispatch #(.NUM_HARTS(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
        .irq_i(zero6), .ipi_i(zero6), .time_irq_i(zero6), .mvu_irq_i(zero6),
        .irq_ack_i(1'b0), .hart_id_o(hart6), .irq_valid_o(v6),
        .irq_o(i6), .ipi_o(p6), .time_irq_o(t6), .mvu_irq_o(m6),
        .cause_o(c6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        if (rst_n && enable_i) begin
            exp_hart = (exp_hart + 1) % 8;
            exp6     = (exp6 + 1) % 6;
        end
        #1;
    endtask

    // src: 0 none, 1 ext, 2 ipi, 3 timer, 4 mvu
    task automatic expect_present(input string tag, input int src);
        logic [4:0]  flags;
        logic [31:0] cause;
        case (src)
            1:       begin flags = 5'b11000; cause = C_EXT; end
            2:       begin flags = 5'b10100; cause = C_IPI; end
            3:       begin flags = 5'b10010; cause = C_TMR; end
            4:       begin flags = 5'b10001; cause = C_MVU; end
            default: begin flags = 5'b00000; cause = '0;    end
        endcase
        check({tag, "_hart"}, 32'(hart_id_o), 32'(exp_hart));
        check({tag, "_flags"}, 32'({irq_valid_o, irq_o, ipi_o, time_irq_o, mvu_irq_o}), 32'(flags));
        check({tag, "_cause"}, cause_o, cause);
    endtask

    // Advance with enable high until the model says slot h, then hold there.
    task automatic goto_slot(input int h);
        enable_i = 1'b1;
        for (int i = 0; i < 8 && exp_hart != h; i++) tick();
        enable_i = 1'b0;
    endtask

    task automatic ack_once();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
    endtask

    // Let any input edge reach the pending register.
    task automatic settle();
        for (int i = 0; i <= LAT; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0; enable_i = 1'b0; irq_ack_i = 1'b0;
        irq_i = '0; ipi_i = '0; time_irq_i = '0; mvu_irq_i = '0;
        #1;
        expect_present("reset", 0);
        tick(); tick();
        rst_n = 1'b1;

        // Slot counter: 20 enabled cycles, both instances.
        enable_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("cnt8", 32'(hart_id_o), 32'((i + 1) % 8));
            check("cnt6", 32'(hart6), 32'((i + 1) % 6));
            check("cnt_idle", 32'({irq_valid_o, cause_o != 0}), 32'd0);
        end
        check("cnt8_model", 32'(hart_id_o), 32'(exp_hart));
        check("cnt6_model", 32'(hart6), 32'(exp6));
        enable_i = 1'b0;
        tick();
        check("cnt_hold", 32'(hart_id_o), 32'd4);

        // External pulse on hart 3, capture latency observed with slot parked on 3.
        goto_slot(3);
        irq_i[3] = 1'b1;
        tick();
        irq_i[3] = 1'b0;
        for (int j = 0; j < LAT; j++) begin
            check("lat_pre", 32'(irq_valid_o), 32'd0);
            tick();
        end
        expect_present("ext3", 1);
        ack_once();
        expect_present("ext3_acked", 0);
        enable_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        enable_i = 1'b0;
        expect_present("ext3_revisit", 0);

        // Timer and IPI together on hart 5: IPI first, then timer.
        time_irq_i[5] = 1'b1; ipi_i[5] = 1'b1;
        settle();
        time_irq_i[5] = 1'b0; ipi_i[5] = 1'b0;
        goto_slot(5);
        expect_present("h5_ipi", 2);
        ack_once();
        expect_present("h5_tmr", 3);
        ack_once();
        expect_present("h5_idle", 0);

        // MVU on hart 2: a new edge landing on the ack edge is retained.
        mvu_irq_i[2] = 1'b1;
        settle();
        mvu_irq_i[2] = 1'b0;
        goto_slot(2);
        expect_present("h2_mvu", 4);
        mvu_irq_i[2] = 1'b1;
        for (int j = 0; j < LAT; j++) begin
            tick();
            mvu_irq_i[2] = 1'b0;
        end
        ack_once();
        mvu_irq_i[2] = 1'b0;
        expect_present("h2_setwins", 4);
        ack_once();
        expect_present("h2_idle", 0);

        // Held level on hart 0 gives one event.
        irq_i[0] = 1'b1;
        enable_i = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        goto_slot(0);
        expect_present("h0_level", 1);
        ack_once();
        expect_present("h0_after_ack", 0);
        enable_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        enable_i = 1'b0;
        expect_present("h0_revisit", 0);
        irq_i[0] = 1'b0;

        // Ack during an idle slot must not disturb other harts.
        time_irq_i[6] = 1'b1;
        settle();
        time_irq_i[6] = 1'b0;
        goto_slot(1);
        expect_present("h1_idle", 0);
        irq_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        irq_ack_i = 1'b0;
        goto_slot(6);
        expect_present("h6_kept", 3);
        ack_once();
        expect_present("h6_idle", 0);

        // Async reset mid-stream with four harts pending.
        irq_i[1] = 1'b1; ipi_i[4] = 1'b1; time_irq_i[6] = 1'b1; mvu_irq_i[7] = 1'b1;
        settle();
        irq_i = '0; ipi_i = '0; time_irq_i = '0; mvu_irq_i = '0;
        goto_slot(4);
        expect_present("pre_rst_h4", 2);
        #2;
        rst_n = 1'b0;
        #1;
        exp_hart = 0; exp6 = 0;
        expect_present("rst_now", 0);
        @(negedge clk);
        rst_n = 1'b1;
        enable_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_rst_valid", 32'(irq_valid_o), 32'd0);
        end
        check("post_rst_hart", 32'(hart_id_o), 32'(exp_hart));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
